// File: rtl/alu_share_arbiter.sv
// One 32-bit ALU shared by two valid/ready requesters with round-robin or fixed-priority arbitration.
// Optional perf counters (Perf_Grant0/1, Perf_Stall) are built when ALU_ARB_PERF_EN is defined.
module alu_share_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int MAX_WAIT   = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Req0_Valid,
    output logic        Req0_Ready,
    input  logic [31:0] Req0_SrcA,
    input  logic [31:0] Req0_SrcB,
    input  logic [1:0]  Req0_ALUControl,
    output logic        Rsp0_Valid,
    input  logic        Rsp0_Ready,
    output logic [31:0] Rsp0_Result,
    output logic [3:0]  Rsp0_Flags,
    input  logic        Req1_Valid,
    output logic        Req1_Ready,
    input  logic [31:0] Req1_SrcA,
    input  logic [31:0] Req1_SrcB,
    input  logic [1:0]  Req1_ALUControl,
    output logic        Rsp1_Valid,
    input  logic        Rsp1_Ready,
    output logic [31:0] Rsp1_Result,
    output logic [3:0]  Rsp1_Flags,
    output logic [3:0]  Dbg_State
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0] Perf_Grant0,
    output logic [15:0] Perf_Grant1,
    output logic [15:0] Perf_Stall
`endif
);

    // Handshake: a transfer happens on a rising edge where Valid and Ready are both high;
    // Valid never depends on Ready, and Ready may depend combinationally on Valid.
    typedef enum logic [1:0] {IDLE, BUSY, DONE} port_state_t;

    port_state_t state0, state0_next, state1, state1_next;
    logic        elig0, elig1, grant0, grant1, p1_wins;
    logic        last;
    logic [3:0]  wait_cnt;
    logic        op_valid, op_owner;
    logic [31:0] op_a, op_b;
    logic [1:0]  op_ctl;
    logic [32:0] alu_sum;
    logic [31:0] alu_res;
    logic        alu_c, alu_v;
    logic [3:0]  alu_flags;

    function automatic port_state_t next_state(input port_state_t st, input logic grant,
                                               input logic rsp_ready);
        port_state_t nxt;
        nxt = st;
        case (st)
            IDLE:    if (grant) nxt = BUSY;
            BUSY:    nxt = DONE;
            DONE:    if (rsp_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

    // Ready is gated by Reset so nothing is accepted while reset is held.
    always_comb begin
        elig0 = !Reset && (state0 == IDLE) && Req0_Valid;
        elig1 = !Reset && (state1 == IDLE) && Req1_Valid;
        if (FIXED_PRIO != 0) p1_wins = (wait_cnt == 4'(MAX_WAIT));
        else                 p1_wins = (last == 1'b0);
        grant0 = elig0 && (!elig1 || !p1_wins);
        grant1 = elig1 && !grant0;
    end

    always_comb begin
        state0_next = next_state(state0, grant0, Rsp0_Ready);
        state1_next = next_state(state1, grant1, Rsp1_Ready);
    end

    assign Req0_Ready = grant0;
    assign Req1_Ready = grant1;
    assign Rsp0_Valid = (state0 == DONE);
    assign Rsp1_Valid = (state1 == DONE);
    assign Dbg_State  = {state1, state0};

    always_comb begin
        alu_sum = 33'd0;
        alu_res = 32'd0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_ctl)
            2'b00: begin
                alu_sum = {1'b0, op_a} + {1'b0, op_b};
                alu_res = alu_sum[31:0];
                alu_c   = alu_sum[32];
                alu_v   = (op_a[31] == op_b[31]) && (alu_res[31] != op_a[31]);
            end
            2'b01: begin
                // Carry out of A + ~B + 1 is the NOT-borrow.
                alu_sum = {1'b0, op_a} + {1'b0, ~op_b} + 33'd1;
                alu_res = alu_sum[31:0];
                alu_c   = alu_sum[32];
                alu_v   = (op_a[31] != op_b[31]) && (alu_res[31] != op_a[31]);
            end
            2'b10:   alu_res = op_a & op_b;
            default: alu_res = op_a | op_b;
        endcase
        alu_flags = {alu_res[31], (alu_res == 32'd0), alu_c, alu_v};
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state0      <= IDLE;
            state1      <= IDLE;
            last        <= 1'b1;
            wait_cnt    <= 4'd0;
            op_valid    <= 1'b0;
            op_owner    <= 1'b0;
            op_a        <= 32'd0;
            op_b        <= 32'd0;
            op_ctl      <= 2'd0;
            Rsp0_Result <= 32'd0;
            Rsp0_Flags  <= 4'd0;
            Rsp1_Result <= 32'd0;
            Rsp1_Flags  <= 4'd0;
        end else begin
            state0   <= state0_next;
            state1   <= state1_next;
            op_valid <= grant0 || grant1;
            if (grant0 || grant1) begin
                last     <= grant1;
                op_owner <= grant1;
                op_a     <= grant1 ? Req1_SrcA : Req0_SrcA;
                op_b     <= grant1 ? Req1_SrcB : Req0_SrcB;
                op_ctl   <= grant1 ? Req1_ALUControl : Req0_ALUControl;
            end
            if ((FIXED_PRIO != 0) && elig1 && !grant1) wait_cnt <= wait_cnt + 4'd1;
            else                                       wait_cnt <= 4'd0;
            // Result of the operand register captured into its owner's response slot.
            if (op_valid) begin
                if (op_owner) begin
                    Rsp1_Result <= alu_res;
                    Rsp1_Flags  <= alu_flags;
                end else begin
                    Rsp0_Result <= alu_res;
                    Rsp0_Flags  <= alu_flags;
                end
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge CLK) begin
        if (Reset) begin
            Perf_Grant0 <= 16'd0;
            Perf_Grant1 <= 16'd0;
            Perf_Stall  <= 16'd0;
        end else begin
            if (grant0 && (Perf_Grant0 != 16'hFFFF)) Perf_Grant0 <= Perf_Grant0 + 16'd1;
            if (grant1 && (Perf_Grant1 != 16'hFFFF)) Perf_Grant1 <= Perf_Grant1 + 16'd1;
            if (elig0 && elig1 && (Perf_Stall != 16'hFFFF)) Perf_Stall <= Perf_Stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a round-robin and a fixed-priority instance driven with identical
// stimulus, checked every cycle against a transaction-level model with an expected-result queue.
module tb_alu_share_arbiter;

    logic        CLK;
    logic        rst;
    logic        req_valid [2][2];
    logic        req_ready [2][2];
    logic [31:0] src_a     [2][2];
    logic [31:0] src_b     [2][2];
    logic [1:0]  ctl       [2][2];
    logic        rsp_valid [2][2];
    logic        rsp_ready [2][2];
    logic [31:0] rsp_res   [2][2];
    logic [3:0]  rsp_flags [2][2];
    logic [3:0]  dbg       [2];
`ifdef ALU_ARB_PERF_EN
    logic [15:0] perf_g0 [2];
    logic [15:0] perf_g1 [2];
    logic [15:0] perf_st [2];
    int          m_g0 [2];
    int          m_g1 [2];
    int          m_st [2];
`endif

    // Reference-model state: per (instance*2+port) slot
    bit          pend     [4];
    int          acc_cyc  [4];
    logic [35:0] exp_q    [4][$];
    logic [35:0] last_rsp [4];
    int          last_ptr [2];
    int          lose_cnt [2];
    int          cyc;
    int          run1;
    int          max_run1;
    int          n_checks;
    int          n_fail;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    alu_share_arbiter #(.FIXED_PRIO(0), .MAX_WAIT(4)) dut (
        .CLK(CLK), .Reset(rst),
        .Req0_Valid(req_valid[0][0]), .Req0_Ready(req_ready[0][0]),
        .Req0_SrcA(src_a[0][0]), .Req0_SrcB(src_b[0][0]), .Req0_ALUControl(ctl[0][0]),
        .Rsp0_Valid(rsp_valid[0][0]), .Rsp0_Ready(rsp_ready[0][0]),
        .Rsp0_Result(rsp_res[0][0]), .Rsp0_Flags(rsp_flags[0][0]),
        .Req1_Valid(req_valid[0][1]), .Req1_Ready(req_ready[0][1]),
        .Req1_SrcA(src_a[0][1]), .Req1_SrcB(src_b[0][1]), .Req1_ALUControl(ctl[0][1]),
        .Rsp1_Valid(rsp_valid[0][1]), .Rsp1_Ready(rsp_ready[0][1]),
        .Rsp1_Result(rsp_res[0][1]), .Rsp1_Flags(rsp_flags[0][1]),
        .Dbg_State(dbg[0])
`ifdef ALU_ARB_PERF_EN
        , .Perf_Grant0(perf_g0[0]), .Perf_Grant1(perf_g1[0]), .Perf_Stall(perf_st[0])
`endif
    );

    alu_share_arbiter #(.FIXED_PRIO(1), .MAX_WAIT(4)) dut_fp (
        .CLK(CLK), .Reset(rst),
        .Req0_Valid(req_valid[1][0]), .Req0_Ready(req_ready[1][0]),
        .Req0_SrcA(src_a[1][0]), .Req0_SrcB(src_b[1][0]), .Req0_ALUControl(ctl[1][0]),
        .Rsp0_Valid(rsp_valid[1][0]), .Rsp0_Ready(rsp_ready[1][0]),
        .Rsp0_Result(rsp_res[1][0]), .Rsp0_Flags(rsp_flags[1][0]),
        .Req1_Valid(req_valid[1][1]), .Req1_Ready(req_ready[1][1]),
        .Req1_SrcA(src_a[1][1]), .Req1_SrcB(src_b[1][1]), .Req1_ALUControl(ctl[1][1]),
        .Rsp1_Valid(rsp_valid[1][1]), .Rsp1_Ready(rsp_ready[1][1]),
        .Rsp1_Result(rsp_res[1][1]), .Rsp1_Flags(rsp_flags[1][1]),
        .Dbg_State(dbg[1])
`ifdef ALU_ARB_PERF_EN
        , .Perf_Grant0(perf_g0[1]), .Perf_Grant1(perf_g1[1]), .Perf_Stall(perf_st[1])
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // {result, N, Z, C, V} computed from signed/unsigned arithmetic on wide integers
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        longint sa, sb, sr, ua, ub;
        logic [31:0] r;
        logic c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'd0: begin
                r = a + b;
                sr = longint'($signed(r));
                c = (ua + ub) > 64'hFFFF_FFFF;
                v = (sa + sb) != sr;
            end
            2'd1: begin
                r = a - b;
                sr = longint'($signed(r));
                c = (ua >= ub);
                v = (sa - sb) != sr;
            end
            2'd2:    r = a & b;
            default: r = a | b;
        endcase
        return {r, r[31], (r == 32'd0), c, v};
    endfunction

    task automatic model_reset(input int i);
        for (int p = 0; p < 2; p++) begin
            pend[i*2+p] = 1'b0;
            exp_q[i*2+p].delete();
            last_rsp[i*2+p] = 36'd0;
        end
        last_ptr[i] = 1;
        lose_cnt[i] = 0;
`ifdef ALU_ARB_PERF_EN
        m_g0[i] = 0;
        m_g1[i] = 0;
        m_st[i] = 0;
`endif
    endtask

    task automatic drive(input int p, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
        for (int i = 0; i < 2; i++) begin
            req_valid[i][p] = v;
            src_a[i][p] = a;
            src_b[i][p] = b;
            ctl[i][p] = op;
        end
    endtask

    task automatic set_rsp_ready(input int p, input logic r);
        for (int i = 0; i < 2; i++) rsp_ready[i][p] = r;
    endtask

    // One clock: called just after a falling edge with inputs already driven.
    task automatic cycle();
        logic e0, e1, exp_v;
        int win, idx;
        #1;
        for (int i = 0; i < 2; i++) begin
            e0 = req_valid[i][0] && !pend[i*2];
            e1 = req_valid[i][1] && !pend[i*2+1];
            win = -1;
            if (!rst) begin
                if (e0 && e1) begin
                    if (i == 0) win = (last_ptr[i] == 1) ? 0 : 1;
                    else        win = (lose_cnt[i] == 4) ? 1 : 0;
                end else if (e0) win = 0;
                else if (e1)     win = 1;
            end
            check_val($sformatf("ready0_i%0d", i), 64'(req_ready[i][0]), 64'(win == 0));
            check_val($sformatf("ready1_i%0d", i), 64'(req_ready[i][1]), 64'(win == 1));
            for (int p = 0; p < 2; p++) begin
                idx = i*2 + p;
                exp_v = pend[idx] && (cyc >= acc_cyc[idx] + 2);
                check_val($sformatf("rsp_valid_i%0d_p%0d", i, p), 64'(rsp_valid[i][p]), 64'(exp_v));
                if (exp_v) begin
                    check_val($sformatf("rsp_data_i%0d_p%0d", i, p),
                              64'({rsp_res[i][p], rsp_flags[i][p]}), 64'(exp_q[idx][0]));
                    last_rsp[idx] = exp_q[idx][0];
                    if (rsp_ready[i][p]) begin
                        void'(exp_q[idx].pop_front());
                        pend[idx] = 1'b0;
                    end
                end else begin
                    check_val($sformatf("rsp_hold_i%0d_p%0d", i, p),
                              64'({rsp_res[i][p], rsp_flags[i][p]}), 64'(last_rsp[idx]));
                end
            end
`ifdef ALU_ARB_PERF_EN
            check_val($sformatf("perf_g0_i%0d", i), 64'(perf_g0[i]), 64'(m_g0[i]));
            check_val($sformatf("perf_g1_i%0d", i), 64'(perf_g1[i]), 64'(m_g1[i]));
            check_val($sformatf("perf_st_i%0d", i), 64'(perf_st[i]), 64'(m_st[i]));
            if (win == 0 && m_g0[i] < 65535) m_g0[i]++;
            if (win == 1 && m_g1[i] < 65535) m_g1[i]++;
            if (!rst && e0 && e1 && m_st[i] < 65535) m_st[i]++;
`endif
            if (win >= 0) begin
                idx = i*2 + win;
                pend[idx] = 1'b1;
                acc_cyc[idx] = cyc;
                exp_q[idx].push_back(alu_ref(src_a[i][win], src_b[i][win], ctl[i][win]));
                last_ptr[i] = win;
            end
            if (e1 && win != 1) lose_cnt[i]++;
            else                lose_cnt[i] = 0;
            if (i == 1) begin
                if (rst) run1 = 0;
                else if (e1) begin
                    run1++;
                    if (win == 1) begin
                        if (run1 > max_run1) max_run1 = run1;
                        run1 = 0;
                    end
                end else run1 = 0;
            end
            if (rst) model_reset(i);
        end
        cyc++;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic wait_rsp(input int p, input logic [31:0] res, input logic [3:0] flg,
                            input string tag);
        int n;
        n = 0;
        while (!rsp_valid[0][p] && n < 10) begin
            cycle();
            n++;
        end
        check_val({tag, "_valid"}, 64'(rsp_valid[0][p]), 64'd1);
        check_val({tag, "_result"}, 64'(rsp_res[0][p]), 64'(res));
        check_val({tag, "_flags"}, 64'(rsp_flags[0][p]), 64'(flg));
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        run1 = 0;
        max_run1 = 0;
        model_reset(0);
        model_reset(1);
        rst = 1'b1;
        for (int p = 0; p < 2; p++) begin
            drive(p, 1'b0, 32'd0, 32'd0, 2'd0);
            set_rsp_ready(p, 1'b1);
        end
        repeat (3) @(posedge CLK);
        @(negedge CLK);

        // Reset state with both requests already valid; then contention on the first free cycle.
        drive(0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'd2);
        drive(1, 1'b1, 32'h0000_000F, 32'h0000_00F0, 2'd3);
        cycle();
        rst = 1'b0;
        #1 check_val("first_grant_p0", 64'(req_ready[0][0]), 64'd1);
        cycle();
        drive(0, 1'b0, 32'd0, 32'd0, 2'd0);
        #1 check_val("second_grant_p1", 64'(req_ready[0][1]), 64'd1);
        cycle();
        drive(1, 1'b0, 32'd0, 32'd0, 2'd0);
        wait_rsp(0, 32'hF000_F000, 4'b1000, "and_p0");
        wait_rsp(1, 32'h0000_00FF, 4'b0000, "or_p1");
        cycle();

        // Signed overflow on ADD, then SUB equal and SUB with borrow
        drive(0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 2'd0);
        cycle();
        drive(0, 1'b0, 32'd0, 32'd0, 2'd0);
        wait_rsp(0, 32'h8000_0000, 4'b1001, "add_ovf");
        cycle();
        drive(1, 1'b1, 32'd5, 32'd5, 2'd1);
        cycle();
        drive(1, 1'b0, 32'd0, 32'd0, 2'd0);
        wait_rsp(1, 32'h0000_0000, 4'b0110, "sub_eq");
        cycle();
        drive(1, 1'b1, 32'd3, 32'd5, 2'd1);
        cycle();
        drive(1, 1'b0, 32'd0, 32'd0, 2'd0);
        wait_rsp(1, 32'hFFFF_FFFE, 4'b1000, "sub_borrow");
        cycle();

        // Response backpressure with port 0 still requesting new work
        set_rsp_ready(0, 1'b0);
        drive(0, 1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 2'd1);
        cycle();
        repeat (6) begin
            drive(0, 1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
            cycle();
        end
        set_rsp_ready(0, 1'b1);
        #1 check_val("bp_no_accept_at_hs", 64'(req_ready[0][0]), 64'd0);
        cycle();
        #1 check_val("bp_accept_after_hs", 64'(req_ready[0][0]), 64'd1);
        cycle();
        drive(0, 1'b0, 32'd0, 32'd0, 2'd0);
        repeat (4) cycle();

        // Sustained contention: fixed-priority port 1 must not starve
        repeat (40) begin
            drive(0, 1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
            drive(1, 1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
            cycle();
        end
        check_val("fp_p1_wait_bound", 64'(max_run1 <= 5), 64'd1);
        drive(0, 1'b0, 32'd0, 32'd0, 2'd0);
        drive(1, 1'b0, 32'd0, 32'd0, 2'd0);
        repeat (4) cycle();

        // Reset while port 0 is in flight: its result must never appear
        drive(0, 1'b1, 32'd1, 32'd2, 2'd0);
        cycle();
        drive(0, 1'b0, 32'd0, 32'd0, 2'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_val("rst_mid_valid", 64'(rsp_valid[0][0]), 64'd0);
        check_val("rst_mid_result", 64'(rsp_res[0][0]), 64'd0);
        repeat (4) cycle();

        // Randomized traffic with occasional resets
        repeat (600) begin
            for (int p = 0; p < 2; p++) begin
                drive(p, 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)));
                set_rsp_ready(p, ($urandom_range(0, 9) < 7));
            end
            rst = ($urandom_range(0, 79) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
